// File: rtl/pll_reset_seq.sv
// pll_reset_seq: filters PLL lock, releases per-domain resets in order, retries the PLL on lock timeout.
module pll_reset_seq #(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_FILTER  = 1024,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int PLL_RST_LEN  = 16,
    parameter int STAGE_DELAY  = 256,
    parameter int NUM_RST      = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               locked,
    input  logic               soft_rst,
    output logic [NUM_RST-1:0] rst_out,
    output logic               ready,
    output logic               pll_rst,
    output logic [7:0]         lock_loss_cnt,
    output logic [3:0]         retry_cnt
);
    localparam int REL_LEN = STAGE_DELAY * NUM_RST;
    localparam int M0 = LOCK_TIMEOUT > LOCK_FILTER ? LOCK_TIMEOUT : LOCK_FILTER;
    localparam int M1 = M0 > PLL_RST_LEN ? M0 : PLL_RST_LEN;
    localparam int M2 = M1 > REL_LEN ? M1 : REL_LEN;
    localparam int CW = M2 > 2 ? $clog2(M2) : 1;

    localparam logic [2:0] S_WAIT = 3'd0;
    localparam logic [2:0] S_PLL  = 3'd1;
    localparam logic [2:0] S_FILT = 3'd2;
    localparam logic [2:0] S_REL  = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;

    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;
    logic [2:0]             state, nxt;
    logic [CW-1:0]          cnt;
    logic                   abort, drop;
    logic [NUM_RST-1:0]     rel_hit;

    assign locked_s = sync[SYNC_STAGES-1];
    // soft_rst is ignored during the PLL pulse; the pulse ends in WAIT_LOCK anyway
    assign abort = soft_rst && state != S_PLL;
    assign drop  = !soft_rst && !locked_s && (state == S_REL || state == S_RUN);

    always_comb begin
        nxt = state;
        if (abort)
            nxt = S_WAIT;
        else
            case (state)
                S_WAIT:  nxt = locked_s ? S_FILT : cnt == CW'(LOCK_TIMEOUT - 1) ? S_PLL : S_WAIT;
                S_PLL:   nxt = cnt == CW'(PLL_RST_LEN - 1) ? S_WAIT : S_PLL;
                S_FILT:  nxt = !locked_s ? S_WAIT : cnt == CW'(LOCK_FILTER - 1) ? S_REL : S_FILT;
                S_REL:   nxt = !locked_s ? S_WAIT : cnt == CW'(REL_LEN - 1) ? S_RUN : S_REL;
                S_RUN:   nxt = !locked_s ? S_WAIT : S_RUN;
                default: nxt = S_WAIT;
            endcase
    end

    always_comb begin
        rel_hit = '0;
        for (int i = 0; i < NUM_RST; i++)
            rel_hit[i] = state == S_REL && cnt == CW'(STAGE_DELAY * (i + 1) - 1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync          <= '0;
            state         <= S_WAIT;
            cnt           <= '0;
            rst_out       <= '1;
            ready         <= 1'b0;
            pll_rst       <= 1'b0;
            lock_loss_cnt <= '0;
            retry_cnt     <= '0;
        end else begin
            sync    <= SYNC_STAGES'({sync, locked});
            state   <= nxt;
            cnt     <= (nxt != state || abort || state == S_RUN) ? '0 : cnt + 1'b1;
            rst_out <= (nxt == S_REL || nxt == S_RUN) ? rst_out & ~rel_hit : '1;
            ready   <= nxt == S_RUN;
            pll_rst <= nxt == S_PLL;
            if (nxt == S_PLL && state != S_PLL && retry_cnt != 4'hf)
                retry_cnt <= retry_cnt + 4'd1;
            if (drop && lock_loss_cnt != 8'hff)
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed scenarios plus random lock/soft_rst traffic checked against a phase/elapsed-time model.
module tb_pll_reset_seq;
    localparam int SS = 2, LF = 8, LT = 64, PL = 4, SD = 4, NR = 3;

    logic          clk = 0, resetn = 0, locked = 0, soft_rst = 0;
    logic [NR-1:0] rst_out;
    logic          ready, pll_rst;
    logic [7:0]    lock_loss_cnt;
    logic [3:0]    retry_cnt;
    int            n_chk = 0, n_fail = 0;

    // model: phase 0 wait, 1 pll reset, 2 filter, 3 release-or-run; t = cycles spent in phase
    int            ph = 0, t = 0, m_loss = 0, m_retry = 0;
    logic [SS-1:0] ms = '0;
    logic          m_ls;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .SYNC_STAGES(SS), .LOCK_FILTER(LF), .LOCK_TIMEOUT(LT),
        .PLL_RST_LEN(PL), .STAGE_DELAY(SD), .NUM_RST(NR)
    ) dut (
        .clk(clk), .resetn(resetn), .locked(locked), .soft_rst(soft_rst),
        .rst_out(rst_out), .ready(ready), .pll_rst(pll_rst),
        .lock_loss_cnt(lock_loss_cnt), .retry_cnt(retry_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; t = 0; m_loss = 0; m_retry = 0; ms = '0;
    endtask

    task automatic step();
        if (!resetn) begin
            model_reset();
            return;
        end
        m_ls = ms[SS-1];
        ms = {ms[SS-2:0], locked};
        case (ph)
            0: if (soft_rst) t = 0;
               else if (m_ls) begin ph = 2; t = 0; end
               else if (t == LT - 1) begin ph = 1; t = 0; if (m_retry < 15) m_retry++; end
               else t++;
            1: if (t == PL - 1) begin ph = 0; t = 0; end else t++;
            2: if (soft_rst || !m_ls) begin ph = 0; t = 0; end
               else if (t == LF - 1) begin ph = 3; t = 0; end
               else t++;
            default: if (soft_rst) begin ph = 0; t = 0; end
               else if (!m_ls) begin ph = 0; t = 0; if (m_loss < 255) m_loss++; end
               else if (t < 100000) t++;
        endcase
    endtask

    task automatic compare_all();
        logic [NR-1:0] er;
        for (int i = 0; i < NR; i++) er[i] = !(ph == 3 && t >= SD * (i + 1));
        check("rst_out", 32'(rst_out), 32'(er));
        check("ready", 32'(ready), 32'(ph == 3 && t >= SD * NR));
        check("pll_rst", 32'(pll_rst), 32'(ph == 1));
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
        check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            step();
            @(negedge clk);
            compare_all();
        end
    endtask

    initial begin
        int pulses;
        tick(3);
        check("reset_rst_out", 32'(rst_out), 32'h7);
        check("reset_ready", 32'(ready), 0);
        resetn = 1;
        // glitch: lock shorter than the filter window
        tick(5);
        locked = 1;
        tick(5);
        locked = 0;
        tick(10);
        check("glitch_rst_out", 32'(rst_out), 32'h7);
        check("glitch_loss", 32'(lock_loss_cnt), 0);
        // clean lock
        locked = 1;
        tick(30);
        check("lock_ready", 32'(ready), 1);
        check("lock_rst_out", 32'(rst_out), 0);
        // lock loss in RUN
        locked = 0;
        tick(3);
        check("loss_rst_out", 32'(rst_out), 32'h7);
        check("loss_ready", 32'(ready), 0);
        check("loss_cnt", 32'(lock_loss_cnt), 1);
        locked = 1;
        tick(30);
        check("relock_ready", 32'(ready), 1);
        // soft_rst coincident with synced lock drop
        locked = 0;
        tick(2);
        soft_rst = 1;
        tick(1);
        soft_rst = 0;
        locked = 1;
        check("soft_rst_out", 32'(rst_out), 32'h7);
        check("soft_loss", 32'(lock_loss_cnt), 1);
        tick(30);
        check("soft_ready", 32'(ready), 1);
        // async reset mid-RELEASE at T0+6
        locked = 0;
        tick(3);
        locked = 1;
        tick(17);
        check("mid_release_rst_out", 32'(rst_out), 32'h6);
        #2 resetn = 0;
        model_reset();
        #1;
        check("async_rst_out", 32'(rst_out), 32'h7);
        check("async_ready", 32'(ready), 0);
        check("async_loss", 32'(lock_loss_cnt), 0);
        check("async_retry", 32'(retry_cnt), 0);
        tick(2);
        resetn = 1;
        tick(30);
        check("restart_ready", 32'(ready), 1);
        // never lock: one pulse of PL cycles, then saturate retries
        resetn = 0;
        locked = 0;
        tick(1);
        resetn = 1;
        pulses = 0;
        repeat (70) begin
            tick(1);
            if (pll_rst === 1'b1) pulses++;
        end
        check("pll_pulse_len", 32'(pulses), PL);
        check("retry_one", 32'(retry_cnt), 1);
        tick(20 * (LT + PL));
        check("retry_sat", 32'(retry_cnt), 15);
        // random traffic
        for (int k = 0; k < 60; k++) begin
            locked = $urandom_range(0, 3) != 0;
            soft_rst = $urandom_range(0, 7) == 0;
            tick(1);
            soft_rst = 0;
            tick($urandom_range(0, 40));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
